// File: rtl/voxel_fetch.sv
// ----------------------------------------------------------------------------
// voxel_fetch
//
// Streams a contiguous array of 32-bit voxel words from memory into a small
// output FIFO. A one-cycle start latches the byte base address and word count.
// The block then issues pipelined Avalon-MM reads (one word per accepted read)
// and pushes returned words into the FIFO, where a valid/ready consumer drains
// them. A credit rule stops the FIFO from overflowing. The rule is that reads
// in flight plus words already buffered never exceed the FIFO depth.
//
// Parameters
//   FIFO_DEPTH       output FIFO depth in words (power of two, 2..64)
//   MAX_OUTSTANDING  maximum reads in flight (1..FIFO_DEPTH)
//
// Ports
//   clock            rising-edge clock
//   reset            asynchronous active-low reset
//   start            one-cycle fetch trigger, honoured only when idle
//   base_addr        byte address of the voxel array
//   count            number of 32-bit words to fetch (0 is legal)
//   busy             fetch in progress
//   done             one-cycle pulse on completion
//   m1_*             Avalon-MM pipelined read master
//   vox_data         FIFO head word (zero while the FIFO is empty)
//   vox_valid        FIFO non-empty
//   vox_ready        downstream accepts the head word
// ----------------------------------------------------------------------------
module voxel_fetch #(
  parameter int FIFO_DEPTH      = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [31:0] count,
  output logic        busy,
  output logic        done,
  output logic [31:0] m1_address,
  output logic        m1_read,
  input  logic        m1_waitrequest,
  input  logic [31:0] m1_readdata,
  input  logic        m1_readdatavalid,
  output logic [31:0] vox_data,
  output logic        vox_valid,
  input  logic        vox_ready
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int USED_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Latched fetch parameters and progress counters
  logic [31:0] r_base;
  logic [31:0] r_count;
  logic [31:0] r_issued;
  logic [31:0] r_received;
  logic [31:0] r_outstanding;

  // Output FIFO storage and bookkeeping
  logic [31:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [USED_W-1:0] r_used;

  logic        w_start_ok;
  logic        w_accept;
  logic        w_rsp;
  logic        w_pop;
  logic        w_can_issue;
  logic        w_last_issue;
  logic        w_drained;
  logic [32:0] w_credit;

  // Handshake qualifiers. Responses that arrive while idle are stale. They
  // come from a fetch that a reset abandoned, so they are dropped.
  assign w_start_ok = (r_state == IDLE) && start;
  assign w_accept   = m1_read && !m1_waitrequest;
  assign w_rsp      = m1_readdatavalid && (r_state != IDLE);
  assign w_pop      = vox_valid && vox_ready;

  // FIFO space is reserved when a read is issued, not when its data returns.
  // A returning word therefore always finds a free slot. A response moves one
  // credit from outstanding to used, so the sum cannot rise while a request
  // waits. m1_read stays asserted through waitrequest.
  assign w_credit    = {1'b0, r_outstanding} + 33'(r_used);
  assign w_can_issue = (r_issued < r_count) &&
                       (r_outstanding < 32'(MAX_OUTSTANDING)) &&
                       (w_credit < 33'(FIFO_DEPTH));

  assign w_last_issue = w_accept && ((r_issued + 32'd1) == r_count);
  assign w_drained    = (r_received == r_count) &&
                        (r_outstanding == 32'd0) &&
                        (r_used == '0);

  // The address is derived from registered state only, so it holds naturally
  // while the slave stalls. The 32-bit add wraps past the top of memory.
  assign m1_address = r_base + {r_issued[29:0], 2'b00};

  assign busy      = (r_state != IDLE);
  assign vox_valid = (r_used != '0);
  assign vox_data  = vox_valid ? r_mem[r_rd_ptr] : 32'd0;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic plus the read strobe and the completion pulse
  always_comb begin
    w_next_state = r_state;
    m1_read      = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = (count == 32'd0) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        m1_read = w_can_issue;
        if (w_last_issue) begin
          w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (w_drained) begin
          done         = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Fetch parameters and progress counters. A start clears the counters, and
  // that includes any in-flight count left by an abandoned fetch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_base        <= 32'd0;
      r_count       <= 32'd0;
      r_issued      <= 32'd0;
      r_received    <= 32'd0;
      r_outstanding <= 32'd0;
    end else if (w_start_ok) begin
      r_base        <= base_addr;
      r_count       <= count;
      r_issued      <= 32'd0;
      r_received    <= 32'd0;
      r_outstanding <= 32'd0;
    end else begin
      if (w_accept) begin
        r_issued <= r_issued + 32'd1;
      end
      if (w_rsp) begin
        r_received <= r_received + 32'd1;
      end
      case ({w_accept, w_rsp})
        2'b10:   r_outstanding <= r_outstanding + 32'd1;
        2'b01:   r_outstanding <= r_outstanding - 32'd1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // FIFO storage has no reset. Nothing reads it while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (w_rsp) begin
      r_mem[r_wr_ptr] <= m1_readdata;
    end
  end

  // FIFO pointers and occupancy. A push and a pop in the same cycle cancel.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_used   <= '0;
    end else begin
      if (w_rsp) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_rsp, w_pop})
        2'b10:   r_used <= r_used + USED_W'(1);
        2'b01:   r_used <= r_used - USED_W'(1);
        default: r_used <= r_used;
      endcase
    end
  end

endmodule

// File: doc/voxel_fetch.md
VOXEL_FETCH -- requirements
Module: voxel_fetch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning the output FIFO depth in words (power of two, 2..64).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of reads in flight (1..FIFO_DEPTH).
REQ-003 SHALL have port clock, input, 1 bit: the only clock, rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle fetch trigger.
REQ-006 SHALL have port base_addr, input, 32 bits: byte address of voxel array (voxel_buffer register).
REQ-007 SHALL have port count, input, 32 bits: number of 32-bit voxel words to fetch (voxel_count register).
REQ-008 SHALL have port busy, output, 1 bit: fetch in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have Avalon-MM read-master ports m1_address (out, 32), m1_read (out, 1), m1_waitrequest (in, 1), m1_readdata (in, 32) and m1_readdatavalid (in, 1).
REQ-011 SHALL have port vox_data, output, 32 bits: FIFO head word.
REQ-012 SHALL have port vox_valid, output, 1 bit: FIFO non-empty.
REQ-013 SHALL have port vox_ready, input, 1 bit: downstream accept.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE and DRAIN.
REQ-015 IDLE + start: SHALL latch base_addr and count, clear the issued, received and outstanding counters, assert busy next cycle and enter ISSUE; if count==0, SHALL go straight to DRAIN instead.
REQ-016 SHALL ignore start when not in IDLE, with no effect on the latched values.
REQ-017 ISSUE: SHALL assert m1_read when issued<count, outstanding<MAX_OUTSTANDING and fifo_used+outstanding<FIFO_DEPTH.
REQ-018 ISSUE: SHALL drive m1_address = latched base + 4*issued, computed mod 2^32 so the address wraps.
REQ-019 SHALL hold m1_read and m1_address stable while m1_waitrequest=1; a read is accepted only on a cycle with m1_read=1 and m1_waitrequest=0, which increments issued.
REQ-020 SHALL increment outstanding on read acceptance and decrement it on m1_readdatavalid; both in the same cycle leaves it unchanged.
REQ-021 On m1_readdatavalid outside IDLE, SHALL write m1_readdata to the FIFO tail and increment received; the credit rule guarantees the FIFO never overflows.
REQ-022 SHALL return data in issue order, relying on Avalon pipelined-read ordering.
REQ-023 SHALL go ISSUE->DRAIN on the cycle issued reaches count.
REQ-024 DRAIN->IDLE SHALL occur when received==count, outstanding==0 and the FIFO is empty; done SHALL pulse 1 for exactly that transition cycle and busy SHALL deassert next cycle.
REQ-025 Output stream: vox_valid = FIFO non-empty and vox_data = head, with a pop on vox_valid&vox_ready; simultaneous push and pop SHALL keep occupancy unchanged.
REQ-026 SHALL keep vox_data stable while vox_valid=1 and vox_ready=0.
REQ-027 SHALL drop m1_readdatavalid while in IDLE (stale responses).
REQ-028 Fetch-to-first-word latency SHALL be start + 1 cycle to m1_read, then read latency + 1 cycle to vox_valid.
REQ-029 SHALL use 32-bit counters; count up to 2^32-1 is legal.

Reset
REQ-030 reset=0 SHALL asynchronously force IDLE, busy=0, done=0, m1_read=0, m1_address=0, vox_valid=0, vox_data=0, FIFO empty and all counters 0.
REQ-031 Reset mid-fetch SHALL discard the FIFO and in-flight state; no done pulse.
REQ-032 Release SHALL be synchronous to clock, with the first start honoured on the first cycle after release.

Verification
REQ-033 Scenario: base=0x1000, count=3, zero-latency slave, vox_ready=1 -> addresses 0x1000, 0x1004, 0x1008; vox_data in order; one done pulse; busy low afterwards.
REQ-034 Scenario: count=0 -> no m1_read ever; done pulses within 2 cycles of start.
REQ-035 Scenario: vox_ready=0, count=20, FIFO_DEPTH=8 -> reads stall with fifo_used+outstanding<=8; releasing vox_ready delivers all 20 words in order.
REQ-036 Scenario: random m1_waitrequest plus read latency 1-5 -> address/read held during wait; outstanding never exceeds 4; data order preserved.
REQ-037 Scenario: base=0xFFFFFFF8, count=4 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
REQ-038 Scenario: reset pulsed after 2 of 10 words, then a stale readdatavalid -> FIFO empty, no done, stale word dropped; a new start completes correctly.
